// File: rtl/regfile_write_controller.sv
// Writeback queue for the 2R/1W register file: accepts ALU and load results,
// drains them in order onto the write port, and forwards pending data to decode.
module regfile_write_controller #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              drain_en,
  input  logic [ADDR_W-1:0] rd_addr_0,
  input  logic [ADDR_W-1:0] rd_addr_1,
  output logic              fwd_hit_0,
  output logic [DATA_W-1:0] fwd_data_0,
  output logic              fwd_hit_1,
  output logic [DATA_W-1:0] fwd_data_1,
  output logic              rf_write_en,
  output logic [15:0]       rf_write_address_0,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_M1_C = CNT_W'(DEPTH - 1);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [CNT_W-1:0]  count_reg, count_next;
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]  ld_slot;
  logic              rf_write_en_reg;
  logic [15:0]       rf_write_address_reg;
  logic [DATA_W-1:0] rf_write_data_reg;

  logic alu_push, ld_push, pop;

  // Ready depends only on the registered count, so a same-cycle pop never
  // lets the queue overfill.
  always_comb begin
    alu_ready = 1'b0;
    ld_ready  = 1'b0;
    if (!rst) begin
      alu_ready = (count_reg < DEPTH_C);
      ld_ready  = alu_valid ? (count_reg < DEPTH_M1_C) : (count_reg < DEPTH_C);
    end
  end

  assign alu_push = alu_valid && alu_ready;
  assign ld_push  = ld_valid && ld_ready;
  assign pop      = drain_en && (count_reg != '0);
  assign ld_slot  = wr_ptr_reg + PTR_W'(alu_push);

  always_comb begin
    count_next  = count_reg + CNT_W'(alu_push) + CNT_W'(ld_push) - CNT_W'(pop);
    wr_ptr_next = wr_ptr_reg + PTR_W'(alu_push) + PTR_W'(ld_push);
    rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg            <= '0;
      wr_ptr_reg           <= '0;
      rd_ptr_reg           <= '0;
      rf_write_en_reg      <= 1'b0;
      rf_write_address_reg <= '0;
      rf_write_data_reg    <= '0;
    end else begin
      count_reg       <= count_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      rf_write_en_reg <= pop;
      if (pop) begin
        rf_write_address_reg <= {{(16-ADDR_W){1'b0}}, addr_mem[rd_ptr_reg]};
        rf_write_data_reg    <= data_mem[rd_ptr_reg];
      end
    end
  end

  // Storage carries no reset; the count decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (alu_push) begin
      addr_mem[wr_ptr_reg] <= alu_addr;
      data_mem[wr_ptr_reg] <= alu_data;
    end
    if (ld_push) begin
      addr_mem[ld_slot] <= ld_addr;
      data_mem[ld_slot] <= ld_data;
    end
  end

  // Slot gi is the gi-th oldest pending entry; higher gi is younger.
  logic [DEPTH-1:0] live, match_0, match_1;
  logic [PTR_W-1:0] slot_idx [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fwd
      assign slot_idx[gi] = rd_ptr_reg + PTR_W'(gi);
      assign live[gi]     = (CNT_W'(gi) < count_reg);
      assign match_0[gi]  = live[gi] && (addr_mem[slot_idx[gi]] == rd_addr_0);
      assign match_1[gi]  = live[gi] && (addr_mem[slot_idx[gi]] == rd_addr_1);
    end
  endgenerate

  always_comb begin
    fwd_hit_0  = 1'b0;
    fwd_data_0 = '0;
    fwd_hit_1  = 1'b0;
    fwd_data_1 = '0;
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (match_0[k]) begin
          fwd_hit_0  = 1'b1;
          fwd_data_0 = data_mem[slot_idx[k]];
        end
        if (match_1[k]) begin
          fwd_hit_1  = 1'b1;
          fwd_data_1 = data_mem[slot_idx[k]];
        end
      end
    end
  end

  assign rf_write_en        = rf_write_en_reg;
  assign rf_write_address_0 = rf_write_address_reg;
  assign rf_write_data      = rf_write_data_reg;
  assign busy               = (count_reg != '0);

endmodule

// File: tb/tb_regfile_write_controller.sv
// Directed bench for regfile_write_controller: vector table plus hand-written
// sequences for pointer wrap and mid-operation reset.
module tb_regfile_write_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, ld_valid, drain_en;
  logic [4:0]  alu_addr, ld_addr, rd_addr_0, rd_addr_1;
  logic [31:0] alu_data, ld_data;
  logic        alu_ready, ld_ready, fwd_hit_0, fwd_hit_1, rf_write_en, busy;
  logic [31:0] fwd_data_0, fwd_data_1, rf_write_data;
  logic [15:0] rf_write_address_0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_write_controller #(.DEPTH(4), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .drain_en(drain_en), .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1),
    .fwd_hit_0(fwd_hit_0), .fwd_data_0(fwd_data_0),
    .fwd_hit_1(fwd_hit_1), .fwd_data_1(fwd_data_1),
    .rf_write_en(rf_write_en), .rf_write_address_0(rf_write_address_0),
    .rf_write_data(rf_write_data), .busy(busy)
  );

  typedef struct {
    logic av; logic [4:0] aa; logic [31:0] ad;
    logic lv; logic [4:0] la; logic [31:0] ldd;
    logic de; logic [4:0] r0; logic [4:0] r1;
    logic ar; logic lr;
    logic h0; logic [31:0] d0; logic h1; logic [31:0] d1;
    logic we; logic [15:0] wa; logic [31:0] wd; logic bz;
  } vec_t;

  vec_t vecs [19];

  function automatic vec_t mk(
    logic av, logic [4:0] aa, logic [31:0] ad,
    logic lv, logic [4:0] la, logic [31:0] ldd,
    logic de, logic [4:0] r0, logic [4:0] r1,
    logic ar, logic lr, logic h0, logic [31:0] d0, logic h1, logic [31:0] d1,
    logic we, logic [15:0] wa, logic [31:0] wd, logic bz);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad; v.lv = lv; v.la = la; v.ldd = ldd;
    v.de = de; v.r0 = r0; v.r1 = r1; v.ar = ar; v.lr = lr;
    v.h0 = h0; v.d0 = d0; v.h1 = h1; v.d1 = d1;
    v.we = we; v.wa = wa; v.wd = wd; v.bz = bz;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    alu_valid = 0; alu_addr = 0; alu_data = 0;
    ld_valid = 0; ld_addr = 0; ld_data = 0;
    drain_en = 0; rd_addr_0 = 0; rd_addr_1 = 0;
  endtask

  initial begin
    int n;
    // Expected outputs are sampled before the edge that consumes the inputs.
    vecs[0]  = mk(0,0,0,           0,0,0,      1,0,0, 1,1, 0,0,0,0,                  0,16'h0,32'h0,0);
    vecs[1]  = mk(1,5,32'hDEADBEEF,0,0,0,      1,5,0, 1,1, 0,0,0,0,                  0,16'h0,32'h0,0);
    vecs[2]  = mk(0,0,0,           0,0,0,      1,5,5, 1,1, 1,32'hDEADBEEF,1,32'hDEADBEEF, 0,16'h0,32'h0,1);
    vecs[3]  = mk(0,0,0,           0,0,0,      1,5,0, 1,1, 0,0,0,0,                  1,16'h5,32'hDEADBEEF,0);
    vecs[4]  = mk(1,3,32'h11,      1,3,32'h22, 1,3,0, 1,1, 0,0,0,0,                  0,16'h5,32'hDEADBEEF,0);
    vecs[5]  = mk(0,0,0,           0,0,0,      1,3,5, 1,1, 1,32'h22,0,0,             0,16'h5,32'hDEADBEEF,1);
    vecs[6]  = mk(0,0,0,           0,0,0,      1,3,0, 1,1, 1,32'h22,0,0,             1,16'h3,32'h11,1);
    vecs[7]  = mk(0,0,0,           0,0,0,      1,3,0, 1,1, 0,0,0,0,                  1,16'h3,32'h22,0);
    vecs[8]  = mk(1,1,32'hA1,      0,0,0,      0,1,0, 1,1, 0,0,0,0,                  0,16'h3,32'h22,0);
    vecs[9]  = mk(1,2,32'hA2,      0,0,0,      0,1,2, 1,1, 1,32'hA1,0,0,             0,16'h3,32'h22,1);
    vecs[10] = mk(1,1,32'hA3,      0,0,0,      0,1,2, 1,1, 1,32'hA1,1,32'hA2,        0,16'h3,32'h22,1);
    vecs[11] = mk(1,4,32'hA4,      1,4,32'hB4, 0,1,4, 1,0, 1,32'hA3,0,0,             0,16'h3,32'h22,1);
    vecs[12] = mk(0,0,0,           1,5,32'hB5, 0,4,2, 0,0, 1,32'hA4,1,32'hA2,        0,16'h3,32'h22,1);
    vecs[13] = mk(0,0,0,           0,0,0,      1,1,4, 0,0, 1,32'hA3,1,32'hA4,        0,16'h3,32'h22,1);
    vecs[14] = mk(0,0,0,           0,0,0,      1,1,2, 1,1, 1,32'hA3,1,32'hA2,        1,16'h1,32'hA1,1);
    vecs[15] = mk(0,0,0,           0,0,0,      1,2,1, 1,1, 0,0,1,32'hA3,             1,16'h2,32'hA2,1);
    vecs[16] = mk(0,0,0,           0,0,0,      1,1,4, 1,1, 0,0,1,32'hA4,             1,16'h1,32'hA3,1);
    vecs[17] = mk(0,0,0,           0,0,0,      1,4,0, 1,1, 0,0,0,0,                  1,16'h4,32'hA4,0);
    vecs[18] = mk(0,0,0,           0,0,0,      1,0,0, 1,1, 0,0,0,0,                  0,16'h4,32'hA4,0);

    rst = 1'b1;
    drive_idle();
    @(posedge clk); #1;
    alu_valid = 1; ld_valid = 1;
    @(negedge clk);
    chk("rst alu_ready", 32'(alu_ready), 32'd0);
    chk("rst ld_ready", 32'(ld_ready), 32'd0);
    chk("rst fwd_hit_0", 32'(fwd_hit_0), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive_idle();

    for (int i = 0; i < 19; i++) begin
      alu_valid = vecs[i].av; alu_addr = vecs[i].aa; alu_data = vecs[i].ad;
      ld_valid = vecs[i].lv; ld_addr = vecs[i].la; ld_data = vecs[i].ldd;
      drain_en = vecs[i].de; rd_addr_0 = vecs[i].r0; rd_addr_1 = vecs[i].r1;
      @(negedge clk);
      chk($sformatf("v%0d alu_ready", i), 32'(alu_ready), 32'(vecs[i].ar));
      chk($sformatf("v%0d ld_ready", i), 32'(ld_ready), 32'(vecs[i].lr));
      chk($sformatf("v%0d fwd_hit_0", i), 32'(fwd_hit_0), 32'(vecs[i].h0));
      if (vecs[i].h0) chk($sformatf("v%0d fwd_data_0", i), fwd_data_0, vecs[i].d0);
      chk($sformatf("v%0d fwd_hit_1", i), 32'(fwd_hit_1), 32'(vecs[i].h1));
      if (vecs[i].h1) chk($sformatf("v%0d fwd_data_1", i), fwd_data_1, vecs[i].d1);
      chk($sformatf("v%0d rf_write_en", i), 32'(rf_write_en), 32'(vecs[i].we));
      chk($sformatf("v%0d rf_write_address_0", i), 32'(rf_write_address_0), 32'(vecs[i].wa));
      chk($sformatf("v%0d rf_write_data", i), rf_write_data, vecs[i].wd);
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].bz));
      $display("vector %0d applied: alu_v=%0b ld_v=%0b drain=%0b we=%0b addr=%h data=%h",
               i, vecs[i].av, vecs[i].lv, vecs[i].de, rf_write_en, rf_write_address_0, rf_write_data);
      @(posedge clk); #1;
    end

    // Ten back-to-back ALU writes (addr i, data i*3) across pointer wrap.
    n = 0;
    for (int c = 0; c < 14; c++) begin
      drive_idle();
      drain_en = 1;
      if (c < 10) begin
        alu_valid = 1; alu_addr = 5'(c); alu_data = 32'(c * 3);
      end
      @(negedge clk);
      if (c < 10) chk($sformatf("wrap alu_ready c%0d", c), 32'(alu_ready), 32'd1);
      if (rf_write_en) begin
        chk($sformatf("wrap addr #%0d", n), 32'(rf_write_address_0), 32'(n));
        chk($sformatf("wrap data #%0d", n), rf_write_data, 32'(n * 3));
        $display("wrap write %0d: addr=%h data=%h", n, rf_write_address_0, rf_write_data);
        n++;
      end
      @(posedge clk); #1;
    end
    chk("wrap pulse count", 32'(n), 32'd10);

    // Queue three entries with the drain stalled, then reset.
    for (int c = 0; c < 3; c++) begin
      drive_idle();
      alu_valid = 1; alu_addr = 5'(7 + c); alu_data = 32'(70 + 10 * c);
      @(posedge clk); #1;
    end
    drive_idle();
    rd_addr_0 = 7;
    @(negedge clk);
    chk("pre-rst busy", 32'(busy), 32'd1);
    chk("pre-rst fwd_hit_0", 32'(fwd_hit_0), 32'd1);
    chk("pre-rst fwd_data_0", fwd_data_0, 32'd70);
    @(posedge clk); #1;
    rst = 1; drain_en = 1;
    @(negedge clk);
    chk("mid-rst alu_ready", 32'(alu_ready), 32'd0);
    chk("mid-rst fwd_hit_0", 32'(fwd_hit_0), 32'd0);
    chk("mid-rst fwd_data_0", fwd_data_0, 32'd0);
    @(posedge clk); #1;
    rst = 0;
    for (int c = 0; c < 3; c++) begin
      rd_addr_0 = 5'(7 + c);
      @(negedge clk);
      chk($sformatf("post-rst busy c%0d", c), 32'(busy), 32'd0);
      chk($sformatf("post-rst rf_write_en c%0d", c), 32'(rf_write_en), 32'd0);
      chk($sformatf("post-rst fwd_hit_0 c%0d", c), 32'(fwd_hit_0), 32'd0);
      chk($sformatf("post-rst rf_write_address_0 c%0d", c), 32'(rf_write_address_0), 32'd0);
      chk($sformatf("post-rst rf_write_data c%0d", c), rf_write_data, 32'd0);
      $display("post-reset cycle %0d: busy=%0b we=%0b", c, busy, rf_write_en);
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_controller.md
Name: regfile_write_controller

Overview:
Write-side initiator for the 2-read/1-write register file. Accepts writeback requests from the ALU and load paths over valid/ready handshakes and queues them in a small in-order FIFO. Drains one queued entry per cycle onto the register file write port. Forwards pending, not-yet-written data to the two read addresses so decode never reads stale values.

Parameters:
DEPTH, 4, number of queued writeback entries; power of two, minimum 2
ADDR_W, 5, register address width; zero-extended to 16 bits on rf_write_address_0
DATA_W, 32, register data width

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
alu_valid  input  1  ALU writeback request
alu_addr  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
alu_ready  output  1  ALU request accepted this cycle when alu_valid and alu_ready are both high
ld_valid  input  1  load writeback request
ld_addr  input  ADDR_W  load destination register
ld_data  input  DATA_W  load result
ld_ready  output  1  load request accepted this cycle when ld_valid and ld_ready are both high
drain_en  input  1  permits a pop this cycle; low freezes the write port
rd_addr_0  input  ADDR_W  read port 0 address, mirrored from decode
rd_addr_1  input  ADDR_W  read port 1 address
fwd_hit_0  output  1  a pending entry matches rd_addr_0
fwd_data_0  output  DATA_W  youngest matching pending data for port 0
fwd_hit_1  output  1  a pending entry matches rd_addr_1
fwd_data_1  output  DATA_W  youngest matching pending data for port 1
rf_write_en  output  1  register file write_en
rf_write_address_0  output  16  register file write address, {zeros, ADDR_W address}
rf_write_data  output  DATA_W  register file write data
busy  output  1  FIFO count non-zero

Behaviour:
- Reset, synchronous on rst high at a clk edge: count=0, read and write pointers 0, rf_write_en=0, rf_write_address_0=0, rf_write_data=0. While rst is high, alu_ready=0, ld_ready=0, fwd_hit_*=0 and fwd_data_*=0.
- Reset mid-operation discards all queued entries. No rf_write_en pulse occurs in the cycle after reset is asserted.
- Ready is combinational from registered count only, never from valid:
  - alu_ready = (count < DEPTH)
  - ld_ready = (count < DEPTH-1) when alu_valid is high, else (count < DEPTH)
- Push order in one cycle is ALU entry first, then load entry. Up to 2 pushes per cycle.
- Pop condition: drain_en and count>0, evaluated on the pre-edge count.
  - On pop, the head entry is registered onto rf_write_* with rf_write_en=1 for exactly one cycle.
  - Otherwise rf_write_en=0 and address/data hold their last values.
- Latency: a request accepted at edge N into an empty FIFO is popped at edge N+1, so rf_write_en is high during cycle N+1..N+2. No combinational bypass from input to the write port.
- Simultaneous push and pop: next count = count + pushes - pop. Ready does not account for the same-cycle pop, so a full FIFO is never overfilled.
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH+1).
- Writes to address 0 are queued and written like any other address; this block does not special-case r0.
- Forwarding is combinational over valid FIFO entries only. The youngest matching entry wins, youngest meaning closest to the write pointer. Entries already on rf_write_* are excluded because the register file updates combinationally.
- No forwarding of same-cycle inputs: only entries accepted at an earlier edge are forwarded.
- busy = (count != 0).

Test Plan:
- Reset then idle: hold rst 2 cycles, release -> alu_ready=1, ld_ready=1, rf_write_en=0, busy=0, rf_write_address_0=16'h0000.
- Single ALU write: alu_valid with addr=5, data=32'hDEADBEEF for one cycle -> one cycle later rf_write_en=1, rf_write_address_0=16'h0005, rf_write_data=32'hDEADBEEF for exactly one cycle; busy returns to 0.
- Dual push ordering: same cycle ALU (3, 32'h11) and load (3, 32'h22) -> rd_addr_0=3 shows fwd_hit_0=1, fwd_data_0=32'h22. Write port shows addr 3/data 32'h11, then addr 3/data 32'h22 on consecutive cycles.
- Full and backpressure: drain_en=0, push 4 ALU entries -> alu_ready=0, ld_ready=0 at count=4. With count=3 and both valid -> ALU accepted, ld_ready=0. Raise drain_en -> 4 writes in FIFO order, one per cycle.
- Wrap-around: drain_en=1, stream 10 back-to-back ALU writes with addr=i, data=i*3 -> 10 rf_write_en pulses, correct pairs in order, no drop or duplicate across pointer wrap.
- Reset mid-operation: 3 entries queued, drain_en=0, assert rst one cycle -> busy=0, no write pulse after release, and fwd_hit_0=0 for previously pending addresses.
